// File: rtl/mem_arbiter.sv
// Shares one RAM port among per-core icache and dcache requesters.
// Data requests beat instruction requests; each class is round-robin.
module mem_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);
    localparam int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic {IDLE, SERVE} state_t;
    typedef enum logic {CLS_I, CLS_D} cls_t;
    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    state_t          r_state;
    cls_t            r_cls;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] r_i_ptr;
    logic [IDXW-1:0] r_d_ptr;

    logic [CPUS-1:0] w_dreq;
    logic            w_grant_valid;
    cls_t            w_grant_cls;
    logic [IDXW-1:0] w_grant_idx;
    logic            w_serve;
    logic            w_live;
    logic            w_done;
    ramstate_t       w_ramstate;

    // First requester at or after ptr, walking upward with wrap.
    function automatic logic [IDXW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                                input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] pick;
        logic [IDXW-1:0] cand;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            cand = IDXW'((int'(ptr) + k) % CPUS);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] idx);
        return (idx == IDXW'(CPUS - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign w_dreq     = dREN | dWEN;
    assign w_ramstate = ramstate_t'(ramstate);
    assign w_serve    = (r_state == SERVE);
    assign w_live     = (r_cls == CLS_D) ? w_dreq[r_idx] : iREN[r_idx];
    assign w_done     = w_serve && w_live && (w_ramstate == RAM_ACCESS);

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_cls   = CLS_I;
        w_grant_idx   = '0;
        if (|w_dreq) begin
            w_grant_valid = 1'b1;
            w_grant_cls   = CLS_D;
            w_grant_idx   = rr_pick(w_dreq, r_d_ptr);
        end else if (|iREN) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = rr_pick(iREN, r_i_ptr);
        end
    end

    // RAM side follows the owner's live inputs so a dropped request aborts at once.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (w_serve) begin
            if (r_cls == CLS_D) begin
                ramWEN   = dWEN[r_idx];
                ramREN   = dREN[r_idx] & ~dWEN[r_idx];
                ramaddr  = daddr[r_idx];
                ramstore = dstore[r_idx];
            end else begin
                ramREN  = iREN[r_idx];
                ramaddr = iaddr[r_idx];
            end
        end
    end

    always_comb begin
        iwait = '1;
        dwait = '1;
        if (w_done) begin
            if (r_cls == CLS_D) dwait[r_idx] = 1'b0;
            else                iwait[r_idx] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cls   <= CLS_I;
            r_idx   <= '0;
            r_i_ptr <= '0;
            r_d_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_state <= SERVE;
                        r_cls   <= w_grant_cls;
                        r_idx   <= w_grant_idx;
                    end
                end
                SERVE: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        if (r_cls == CLS_D) r_d_ptr <= rr_next(r_idx);
                        else                r_i_ptr <= rr_next(r_idx);
                    end else if (!w_live || w_ramstate == RAM_ERROR) begin
                        // Error or abort: release the port, pointers untouched so it is retried.
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: ifetch, priority, round-robin, write
// precedence, error retry, abort and asynchronous reset.
module tb_mem_arbiter;
    localparam int CPUS = 2;
    localparam logic [1:0] ST_FREE = 2'd0, ST_BUSY = 2'd1, ST_ACCESS = 2'd2, ST_ERROR = 2'd3;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [CPUS-1:0]       iREN;
    logic [CPUS-1:0][31:0] iaddr;
    logic [CPUS-1:0]       iwait;
    logic [CPUS-1:0][31:0] iload;
    logic [CPUS-1:0]       dREN;
    logic [CPUS-1:0]       dWEN;
    logic [CPUS-1:0][31:0] daddr;
    logic [CPUS-1:0][31:0] dstore;
    logic [CPUS-1:0]       dwait;
    logic [CPUS-1:0][31:0] dload;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    logic [1:0]            ramstate;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.CPUS(CPUS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ramREN"}, 32'(ramREN), 32'd0);
        check({tag, " ramWEN"}, 32'(ramWEN), 32'd0);
        check({tag, " iwait"}, 32'(iwait), 32'd3);
        check({tag, " dwait"}, 32'(dwait), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nRST     = 1'b0;
        iREN     = '0;
        iaddr    = '0;
        dREN     = '0;
        dWEN     = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = ST_FREE;
        #2;
        check_idle("reset");
        check("reset ramaddr", ramaddr, 32'h0);
        check("reset ramstore", ramstore, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        step();

        // Single ifetch: BUSY, BUSY, ACCESS.
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h40;
        settle();
        check("if idle ramREN", 32'(ramREN), 32'd0);
        step();
        ramstate = ST_BUSY;
        settle();
        check("if c1 ramREN", 32'(ramREN), 32'd1);
        check("if c1 ramaddr", ramaddr, 32'h40);
        check("if c1 iwait", 32'(iwait), 32'd3);
        step();
        settle();
        check("if c2 iwait", 32'(iwait), 32'd3);
        step();
        ramstate = ST_ACCESS;
        ramload  = 32'h8C010004;
        settle();
        check("if c3 iwait", 32'(iwait), 32'b10);
        check("if c3 iload0", iload[0], 32'h8C010004);
        check("if c3 iload1", iload[1], 32'h8C010004);
        check("if c3 dload0", dload[0], 32'h8C010004);
        step();
        iREN     = '0;
        ramstate = ST_FREE;
        settle();
        check_idle("if end");

        // Data over instruction priority.
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h44;
        dREN[1]  = 1'b1;
        daddr[1] = 32'h100;
        step();
        ramstate = ST_ACCESS;
        settle();
        check("pri d1 ramaddr", ramaddr, 32'h100);
        check("pri d1 ramREN", 32'(ramREN), 32'd1);
        check("pri d1 dwait", 32'(dwait), 32'b01);
        check("pri d1 iwait", 32'(iwait), 32'd3);
        step();
        dREN     = '0;
        ramstate = ST_FREE;
        settle();
        check_idle("pri bubble");
        step();
        ramstate = ST_ACCESS;
        settle();
        check("pri i0 ramaddr", ramaddr, 32'h44);
        check("pri i0 iwait", 32'(iwait), 32'b10);
        step();
        iREN     = '0;
        ramstate = ST_FREE;
        settle();

        // Round-robin among two continuous dcache writers (d_ptr is 0 here).
        daddr[0]  = 32'h200;
        daddr[1]  = 32'h300;
        dstore[0] = 32'h11112222;
        dstore[1] = 32'h33334444;
        dWEN      = 2'b11;
        for (int g = 0; g < 4; g++) begin
            step();
            ramstate = ST_ACCESS;
            settle();
            check($sformatf("rr g%0d ramaddr", g), ramaddr, (g % 2 == 1) ? 32'h300 : 32'h200);
            check($sformatf("rr g%0d dwait", g), 32'(dwait), (g % 2 == 1) ? 32'b01 : 32'b10);
            check($sformatf("rr g%0d ramWEN", g), 32'(ramWEN), 32'd1);
            step();
            ramstate = ST_FREE;
            if (g == 3) dWEN = '0;
            settle();
            check($sformatf("rr g%0d idle ramWEN", g), 32'(ramWEN), 32'd0);
            check($sformatf("rr g%0d idle dwait", g), 32'(dwait), 32'd3);
        end

        // Write wins over read on the same dcache.
        dREN[0]   = 1'b1;
        dWEN[0]   = 1'b1;
        daddr[0]  = 32'h400;
        dstore[0] = 32'hDEADBEEF;
        step();
        ramstate = ST_ACCESS;
        settle();
        check("wp ramWEN", 32'(ramWEN), 32'd1);
        check("wp ramREN", 32'(ramREN), 32'd0);
        check("wp ramstore", ramstore, 32'hDEADBEEF);
        check("wp dwait", 32'(dwait), 32'b10);
        step();
        dREN     = '0;
        dWEN     = '0;
        ramstate = ST_FREE;
        settle();

        // ERROR on dcache 1, retried ahead of dcache 0 since d_ptr stays at 1.
        dREN[1]  = 1'b1;
        daddr[1] = 32'h500;
        step();
        ramstate = ST_ERROR;
        settle();
        check("err ramaddr", ramaddr, 32'h500);
        check("err dwait", 32'(dwait), 32'd3);
        step();
        ramstate = ST_FREE;
        dREN[0]  = 1'b1;
        daddr[0] = 32'h600;
        settle();
        check_idle("err idle");
        step();
        ramstate = ST_ACCESS;
        settle();
        check("retry ramaddr", ramaddr, 32'h500);
        check("retry dwait", 32'(dwait), 32'b01);
        step();
        dREN[1]  = 1'b0;
        ramstate = ST_FREE;
        settle();
        step();
        ramstate = ST_ACCESS;
        settle();
        check("after retry ramaddr", ramaddr, 32'h600);
        check("after retry dwait", 32'(dwait), 32'b10);
        step();
        dREN     = '0;
        ramstate = ST_FREE;
        settle();

        // Abort: icache 1 drops mid-SERVE, i_ptr stays at 1.
        iREN[1]  = 1'b1;
        iaddr[1] = 32'h700;
        step();
        ramstate = ST_BUSY;
        settle();
        check("abort c1 ramaddr", ramaddr, 32'h700);
        check("abort c1 ramREN", 32'(ramREN), 32'd1);
        step();
        iREN[1] = 1'b0;
        settle();
        check("abort drop ramREN", 32'(ramREN), 32'd0);
        check("abort drop iwait", 32'(iwait), 32'd3);
        step();
        iREN     = 2'b11;
        iaddr[0] = 32'h800;
        settle();
        check_idle("abort idle");
        step();
        ramstate = ST_ACCESS;
        settle();
        check("abort regrant ramaddr", ramaddr, 32'h700);
        check("abort regrant iwait", 32'(iwait), 32'b01);
        step();
        iREN[1]  = 1'b0;
        ramstate = ST_FREE;
        settle();
        step();
        ramstate = ST_BUSY;
        settle();
        check("pre-rst ramaddr", ramaddr, 32'h800);
        check("pre-rst ramREN", 32'(ramREN), 32'd1);

        // Asynchronous reset in the middle of SERVE.
        nRST = 1'b0;
        settle();
        check_idle("rst mid");
        check("rst mid ramaddr", ramaddr, 32'h0);
        step();
        nRST     = 1'b1;
        ramstate = ST_FREE;
        settle();
        check_idle("rst release");
        step();
        ramstate = ST_ACCESS;
        settle();
        check("rst regrant ramaddr", ramaddr, 32'h800);
        check("rst regrant iwait", 32'(iwait), 32'b10);
        step();
        iREN     = '0;
        ramstate = ST_FREE;
        settle();
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
